// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Multiplexed BCD-to-7-segment scan driver. Holds an N-digit
//               BCD value, scans it onto a shared segment bus with one-hot
//               digit enables, applies new values only at frame boundaries,
//               blanks leading zeros and inserts a ghost-guard dead cycle at
//               the end of every digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int c_p_width = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_i_width = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_p_width-1:0]  c_p_last   = c_p_width'(SCAN_DIV - 1);
    localparam logic [c_i_width-1:0]  c_i_last   = c_i_width'(NUM_DIGITS - 1);

    // Inactive levels; XOR with these turns active-high internals into pin levels.
    localparam logic                  c_dp_off   = (ACTIVE_LOW != 0);
    localparam logic [6:0]            c_seg_off  = {7{c_dp_off}};
    localparam logic [NUM_DIGITS-1:0] c_an_off   = {NUM_DIGITS{c_dp_off}};
    localparam logic                  c_blank_en = (BLANK_LZ != 0);

    // Active-high {a,b,c,d,e,f,g}; 0xA is a dash, 0xB-0xF are dark.
    function automatic logic [6:0] f_glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b1011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1111011;
            4'hA:    g = 7'b0000001;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    logic [c_p_width-1:0]    r_p;
    logic [c_i_width-1:0]    r_i;
    logic [4*NUM_DIGITS-1:0] r_disp_bcd;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend_bcd;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pend_valid;

    logic                    w_slot_end;
    logic                    w_wrap;
    logic                    w_lit;
    logic [3:0]              w_code;
    logic                    w_dp_sel;
    logic                    w_blank;
    logic                    w_zero_above;
    logic [NUM_DIGITS-1:0]   w_an_hi;
    logic [6:0]              w_seg_hi;

    // The last prescaler count of a slot is the ghost-guard cycle; the last
    // slot's guard cycle is the frame wrap.
    assign w_slot_end = (r_p == c_p_last);
    assign w_wrap     = en && w_slot_end && (r_i == c_i_last);
    assign w_lit      = en && !w_slot_end;

    // Select the current digit and decide leading-zero blanking, scanning
    // from the most significant digit down so w_zero_above accumulates.
    always_comb begin
        w_code       = 4'h0;
        w_dp_sel     = 1'b0;
        w_blank      = 1'b0;
        w_an_hi      = '0;
        w_zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_above = w_zero_above && (r_disp_bcd[4*k +: 4] == 4'h0);
            if (r_i == c_i_width'(k)) begin
                w_code     = r_disp_bcd[4*k +: 4];
                w_dp_sel   = r_disp_dp[k];
                w_an_hi[k] = 1'b1;
                w_blank    = c_blank_en && (k > 0) && w_zero_above;
            end
        end
    end

    assign w_seg_hi = w_blank ? 7'b0000000 : f_glyph(w_code);

    // Prescaler and digit index; both freeze while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
            r_i <= '0;
        end else if (en) begin
            if (w_slot_end) begin
                r_p <= '0;
                r_i <= (r_i == c_i_last) ? '0 : r_i + 1'b1;
            end else begin
                r_p <= r_p + 1'b1;
            end
        end
    end

    // Pending capture and frame-synchronous apply; a load on the wrap cycle
    // bypasses pending so it shows in the frame that starts right away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_bcd   <= '0;
            r_disp_dp    <= '0;
            r_pend_bcd   <= '0;
            r_pend_dp    <= '0;
            r_pend_valid <= 1'b0;
        end else if (load && w_wrap) begin
            r_disp_bcd   <= bcd_in;
            r_disp_dp    <= dp_in;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_wrap && r_pend_valid) begin
                r_disp_bcd   <= r_pend_bcd;
                r_disp_dp    <= r_pend_dp;
                r_pend_valid <= 1'b0;
            end
            if (load) begin
                r_pend_bcd   <= bcd_in;
                r_pend_dp    <= dp_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

    // Output registers with polarity applied; dark when disabled or guarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= c_seg_off;
            dp         <= c_dp_off;
            an         <= c_an_off;
            frame_done <= 1'b0;
        end else begin
            if (w_lit) begin
                seg <= w_seg_hi ^ c_seg_off;
                dp  <= w_dp_sel ^ c_dp_off;
                an  <= w_an_hi ^ c_an_off;
            end else begin
                seg <= c_seg_off;
                dp  <= c_dp_off;
                an  <= c_an_off;
            end
            frame_done <= w_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver. Instance A is the
//               4-digit common-anode build, instance B the 1-digit
//               common-cathode build. Stimulus pushes cycle-tagged expected
//               outputs into queues; a monitor compares them each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_en, a_load;
    logic [15:0] a_bcd;
    logic [3:0]  a_dpin;
    logic [6:0]  a_seg;
    logic        a_dp;
    logic [3:0]  a_an;
    logic        a_fd;

    logic        b_en, b_load;
    logic [3:0]  b_bcd;
    logic [0:0]  b_dpin;
    logic [6:0]  b_seg;
    logic        b_dp;
    logic [0:0]  b_an;
    logic        b_fd;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
        string      name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1), .BLANK_LZ(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .load(a_load),
        .bcd_in(a_bcd), .dp_in(a_dpin),
        .seg(a_seg), .dp(a_dp), .an(a_an), .frame_done(a_fd)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(1), .SCAN_DIV(2), .ACTIVE_LOW(0), .BLANK_LZ(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .load(b_load),
        .bcd_in(b_bcd), .dp_in(b_dpin),
        .seg(b_seg), .dp(b_dp), .an(b_an), .frame_done(b_fd)
    );

    // Clock and edge counter: after rising edge N, cyc == N.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Advance to 1 ns after rising edge n.
    task automatic wait_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Instance A expectation, given in active-high terms (pins are inverted).
    task automatic push_a(input int c, input logic [6:0] seg_hi, input logic dp_hi,
                          input logic [3:0] an_hi, input logic fd, input string name);
        exp_t e;
        e.cyc = c; e.seg = ~seg_hi; e.dp = ~dp_hi; e.an = ~an_hi; e.fd = fd; e.name = name;
        qa.push_back(e);
    endtask

    // Instance B expectation, active-high pins.
    task automatic push_b(input int c, input logic [6:0] seg_hi, input logic dp_hi,
                          input logic an_hi, input logic fd, input string name);
        exp_t e;
        e.cyc = c; e.seg = seg_hi; e.dp = dp_hi; e.an = {3'b000, an_hi}; e.fd = fd; e.name = name;
        qb.push_back(e);
    endtask

    // Slots n in [nfrom..nto] of a 16-cycle frame whose slot 0 appears after
    // edge e0. glyphs = {d3,d2,d1,d0} active-high segment patterns.
    task automatic expect_a(input int e0, input int nfrom, input int nto,
                            input logic [27:0] glyphs, input logic [3:0] dpv,
                            input string name);
        for (int n = nfrom; n <= nto; n++) begin
            if ((n % 4) == 3)
                push_a(e0 + n, 7'h00, 1'b0, 4'h0, (n == 15), name);
            else
                push_a(e0 + n, glyphs[7*(n/4) +: 7], dpv[n/4], 4'b0001 << (n/4), 1'b0, name);
        end
    endtask

    // Monitor: compare whatever is due this cycle, sampled mid-cycle.
    always @(negedge clk) begin
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            ea = qa.pop_front();
            checks++;
            if (ea.cyc != cyc) begin
                failures++;
                $display("FAIL %s (A) expectation for cycle %0d missed, now %0d", ea.name, ea.cyc, cyc);
            end else if ({a_seg, a_dp, a_an, a_fd} !== {ea.seg, ea.dp, ea.an, ea.fd}) begin
                failures++;
                $display("FAIL %s (A) cyc=%0d actual seg=%b dp=%b an=%b fd=%b required seg=%b dp=%b an=%b fd=%b",
                         ea.name, cyc, a_seg, a_dp, a_an, a_fd, ea.seg, ea.dp, ea.an, ea.fd);
            end
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            eb = qb.pop_front();
            checks++;
            if (eb.cyc != cyc) begin
                failures++;
                $display("FAIL %s (B) expectation for cycle %0d missed, now %0d", eb.name, eb.cyc, cyc);
            end else if ({b_seg, b_dp, b_an, b_fd} !== {eb.seg, eb.dp, eb.an[0], eb.fd}) begin
                failures++;
                $display("FAIL %s (B) cyc=%0d actual seg=%b dp=%b an=%b fd=%b required seg=%b dp=%b an=%b fd=%b",
                         eb.name, cyc, b_seg, b_dp, b_an, b_fd, eb.seg, eb.dp, eb.an[0], eb.fd);
            end
        end
    end

    // Instance B: single digit, 2-cycle slot, active-high pins.
    initial begin
        b_en = 1'b1; b_load = 1'b0; b_bcd = 4'h0; b_dpin = 1'b0;
        push_b(18, 7'h00, 1'b0, 1'b0, 1'b0, "b_rst_async");
        wait_edge(20);
        // Slot n appears after edge 21+n; odd n is the guard/wrap cycle.
        for (int n = 0; n <= 5; n++) begin
            if (n % 2 == 1) push_b(21 + n, 7'h00, 1'b0, 1'b0, 1'b1, "b_zero");
            else            push_b(21 + n, 7'b1111110, 1'b0, 1'b1, 1'b0, "b_zero");
        end
        wait_edge(24);
        b_load = 1'b1; b_bcd = 4'hC; b_dpin = 1'b1;
        wait_edge(25);
        b_load = 1'b0;
        for (int n = 6; n <= 11; n++) begin
            if (n % 2 == 1) push_b(21 + n, 7'h00, 1'b0, 1'b0, 1'b1, "b_code_c");
            else            push_b(21 + n, 7'h00, 1'b1, 1'b1, 1'b0, "b_code_c");
        end
    end

    // Instance A stimulus and overall control.
    initial begin
        a_en = 1'b1; a_load = 1'b0; a_bcd = 16'h0000; a_dpin = 4'h0;
        wait_edge(2);
        rst = 1'b0;
        // frame_done is high right after edge 18; reset must clear it at once.
        wait_edge(18);
        rst = 1'b1;
        push_a(18, 7'h00, 1'b0, 4'h0, 1'b0, "rst_async");
        push_a(19, 7'h00, 1'b0, 4'h0, 1'b0, "rst_hold");
        push_a(21, 7'b1111110, 1'b0, 4'b0001, 1'b0, "rst_first_slot");
        expect_a(21, 1, 15, {7'h00, 7'h00, 7'h00, 7'b1111110}, 4'h0, "f0_reset_zero");
        wait_edge(20);
        rst = 1'b0;

        // Frame 0: load 1234 mid-frame, shown in frame 1.
        wait_edge(25);
        a_load = 1'b1; a_bcd = 16'h1234; a_dpin = 4'b0100;
        wait_edge(26);
        a_load = 1'b0;
        expect_a(37, 0, 15, {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}, 4'b0100, "f1_1234");

        // Frame 1: 0007 -> upper three digits blanked.
        wait_edge(41);
        a_load = 1'b1; a_bcd = 16'h0007; a_dpin = 4'h0;
        wait_edge(42);
        a_load = 1'b0;
        expect_a(53, 0, 15, {7'h00, 7'h00, 7'h00, 7'b1110000}, 4'h0, "f2_lz_0007");

        // Frame 2: 0000 -> only digit 0 lit.
        wait_edge(57);
        a_load = 1'b1; a_bcd = 16'h0000;
        wait_edge(58);
        a_load = 1'b0;
        expect_a(69, 0, 15, {7'h00, 7'h00, 7'h00, 7'b1111110}, 4'h0, "f3_lz_0000");

        // Frame 3: 0A05 -> dash stops blanking, digit 1 shows 0.
        wait_edge(73);
        a_load = 1'b1; a_bcd = 16'h0A05;
        wait_edge(74);
        a_load = 1'b0;
        expect_a(85, 0, 15, {7'h00, 7'b0000001, 7'b1111110, 7'b1011011}, 4'h0, "f4_dash");

        // Frame 4: two loads mid-frame, last one wins next frame.
        wait_edge(89);
        a_load = 1'b1; a_bcd = 16'h1111;
        wait_edge(90);
        a_load = 1'b0;
        wait_edge(91);
        a_load = 1'b1; a_bcd = 16'h2222;
        wait_edge(92);
        a_load = 1'b0;
        expect_a(101, 0, 15, {4{7'b1101101}}, 4'h0, "f5_last_wins");

        // Frame 5: pending 5555, then a load on the wrap cycle overrides it.
        wait_edge(105);
        a_load = 1'b1; a_bcd = 16'h5555;
        wait_edge(106);
        a_load = 1'b0;
        wait_edge(115);
        a_load = 1'b1; a_bcd = 16'h9876; a_dpin = 4'b1001;
        wait_edge(116);
        a_load = 1'b0; a_dpin = 4'h0;
        expect_a(117, 0, 15, {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111}, 4'b1001, "f6_wrap_load");
        expect_a(133, 0, 15, {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111}, 4'b1001, "f7_hold");
        // Frame 8: en low for 10 cycles after slot 5, resume at slot 6.
        expect_a(149, 0, 5, {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111}, 4'b1001, "f8_pre_off");
        for (int c = 155; c <= 164; c++)
            push_a(c, 7'h00, 1'b0, 4'h0, 1'b0, "en_off");
        expect_a(159, 6, 15, {7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111}, 4'b1001, "f8_resume");
        expect_a(175, 0, 15, {7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000}, 4'h0, "f9_load_while_off");

        wait_edge(154);
        a_en = 1'b0;
        wait_edge(158);
        a_load = 1'b1; a_bcd = 16'h4321;
        wait_edge(159);
        a_load = 1'b0;
        wait_edge(164);
        a_en = 1'b1;

        wait_edge(195);
        for (int k = 0; k < 50; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            failures++;
            $display("FAIL drain timeout pending A=%0d B=%0d required 0", qa.size(), qb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised multiplexed BCD-to-7-segment display driver for the stopwatch display. It holds an N-digit BCD value and time-multiplexes it onto one shared segment bus plus per-digit enables. It adds a scan prescaler, tear-free frame-synchronous value update, leading-zero blanking, decimal points, a dash glyph, ghost-guard dead time and selectable output polarity. It sits between the stopwatch counter/BCD logic and the board's common-anode or common-cathode display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1); digit NUM_DIGITS-1 is most significant.
SCAN_DIV, 50000, clk cycles per digit slot (>=2).
ACTIVE_LOW, 1, 1 = seg/dp/an asserted low (common anode); 0 = asserted high.
BLANK_LZ, 1, 1 = leading-zero blanking enabled.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous reset, active-high.
en  in  1  scan enable; 0 = display dark, scan frozen.
load  in  1  one-cycle strobe: capture bcd_in/dp_in for display.
bcd_in  in  4*NUM_DIGITS  digit k at bits [4k+3:4k].
dp_in  in  NUM_DIGITS  decimal point per digit.
seg  out  7  {a,b,c,d,e,f,g}, registered.
dp  out  1  decimal point, registered.
an  out  NUM_DIGITS  one-hot digit enable, registered.
frame_done  out  1  one-cycle pulse when scan wraps from last digit to digit 0.

Behaviour:
- Glyphs (active-high {a..g}): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, 0xA=0000001 (dash), 0xB-0xF=0000000 (blank). ACTIVE_LOW inverts seg, dp and an at the output registers.
- State: prescaler p (0..SCAN_DIV-1), digit index i (0..NUM_DIGITS-1), display reg (value+dp), pending reg, pending_valid.
- Reset (async): p=0, i=0, display=0, pending_valid=0, frame_done=0. All of seg, dp and an are inactive: with ACTIVE_LOW=1 they read all-ones; with ACTIVE_LOW=0, all-zeros.
- Scan, en=1: p increments each cycle. When p==SCAN_DIV-1, p->0 and i->i+1, with i wrapping NUM_DIGITS-1->0. On that wrap, frame_done=1 in the next cycle.
- Outputs are registered, one cycle latency. At edge t+1 the outputs reflect state (i,p) at t:
  - If en=0 or p==SCAN_DIV-1 (ghost guard), all outputs are inactive.
  - Otherwise an selects digit i, seg shows the glyph of display digit i, and dp=display dp[i].
  - Each digit is therefore lit SCAN_DIV-1 of every SCAN_DIV cycles.
- en=0: p and i hold, outputs inactive, frame_done=0. Load capture still operates. Re-enabling resumes from the held p and i.
- Load: load=1 copies bcd_in/dp_in into pending and sets pending_valid. A later load before apply overwrites pending (last wins).
- Apply: on the wrap cycle, if pending_valid, pending->display and pending_valid clears. If load coincides with the wrap, bcd_in/dp_in go directly to display and pending_valid clears. A value never changes mid-frame.
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 is blanked (seg inactive) when it and all digits above it equal 0. Digit 0 is never blanked.
  - an is still asserted for a blanked digit, and dp still follows dp_in.
  - Non-zero codes, including 0xA-0xF, stop blanking for the digits below.
- NUM_DIGITS=1: i stays 0 and frame_done pulses every SCAN_DIV cycles.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1. Assert rst mid-scan -> seg=7'h7F, dp=1, an=4'hF and frame_done=0 immediately; after release, an sequence per slot is 1110 x3 cycles, 1111 x1, then 1101...
- load bcd_in=16'h1234, dp_in=4'b0100 -> applied at next wrap. In the following frame digit0 seg=~0110011, digit1 ~1111001, digit2 ~1101101 with dp=0, digit3 ~0110000. frame_done pulses once per 16 cycles.
- load 16'h0007 with BLANK_LZ=1 -> digits 3..1 seg=7'h7F with their an still asserted, digit0 shows 7. Then load 16'h0000 -> only digit0 shows 0. Then 16'h0A05 -> digit2 shows dash (~0000001), digit1 shows 0.
- Issue load 16'h1111 mid-frame, then 16'h2222 two cycles later -> current frame unchanged; next frame shows 2222. A load on the wrap cycle itself takes effect in the frame starting at that wrap.
- en low for 10 cycles mid-slot -> an=4'hF, frame_done=0, p and i frozen; after en high, scan resumes with the same digit and remaining slot count.
- ACTIVE_LOW=0, NUM_DIGITS=1, SCAN_DIV=2 -> an toggles 1,0 and frame_done pulses every 2 cycles. Code 0xC shows seg=0 with an=1.
